// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Thumb fetch-address sequencer with branch redirect and flush.
// Options  : BRANCH_LINK_EN adds br_link input and lr / lr_we outputs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_sequencer #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter int                FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              br_req,
    input  logic              br_cond_en,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [10:0]       br_imm,
    input  logic              cond_ok,
    output logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic              flush,
    output logic              taken,
    output logic              busy
`ifdef BRANCH_LINK_EN
    ,
    input  logic              br_link,
    output logic [ADDR_W-1:0] lr,
    output logic              lr_we
`endif
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_COND  = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    localparam logic [3:0]        FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
    localparam logic [ADDR_W-1:0] PC_AHEAD   = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] HALFWORD   = ADDR_W'(2);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              flush_q, flush_d;
    logic              taken_q, taken_d;
    logic              busy_q, busy_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;

    logic [ADDR_W-1:0] off_cond, off_uncond, tgt_now;
    logic              redir;
    logic [ADDR_W-1:0] redir_tgt;

    // Offsets are halfword counts, so the shift is folded into the extension.
    assign off_cond   = {{(ADDR_W-9){br_imm[7]}}, br_imm[7:0], 1'b0};
    assign off_uncond = {{(ADDR_W-12){br_imm[10]}}, br_imm, 1'b0};
    assign tgt_now    = (br_pc + PC_AHEAD + (br_cond_en ? off_cond : off_uncond))
                        & ~ADDR_W'(1);

`ifdef BRANCH_LINK_EN
    logic              link_pend_q, link_pend_d;
    logic [ADDR_W-1:0] lr_pend_q, lr_pend_d;
    logic [ADDR_W-1:0] lr_q, lr_d;
    logic              lr_we_q, lr_we_d;
    logic              redir_link;
    logic [ADDR_W-1:0] redir_lr;
    logic [ADDR_W-1:0] lr_now;

    assign lr_now = (br_pc + PC_AHEAD) | ADDR_W'(1);
`endif

    always_comb begin
        state_d       = state_q;
        fetch_addr_d  = fetch_addr_q;
        fetch_valid_d = fetch_valid_q;
        flush_d       = 1'b0;
        taken_d       = 1'b0;
        busy_d        = 1'b0;
        cnt_d         = cnt_q;
        tgt_d         = tgt_q;
        redir         = 1'b0;
        redir_tgt     = tgt_q;
`ifdef BRANCH_LINK_EN
        link_pend_d   = link_pend_q;
        lr_pend_d     = lr_pend_q;
        lr_d          = lr_q;
        lr_we_d       = 1'b0;
        redir_link    = link_pend_q;
        redir_lr      = lr_pend_q;
`endif
        case (state_q)
            ST_INIT: begin
                state_d       = ST_RUN;
                fetch_valid_d = 1'b1;
            end
            ST_RUN: begin
                if (br_req) begin
                    if (!br_cond_en) begin
                        redir     = 1'b1;
                        redir_tgt = tgt_now;
`ifdef BRANCH_LINK_EN
                        redir_link = br_link;
                        redir_lr   = lr_now;
`endif
                    end else begin
                        tgt_d         = tgt_now;
                        fetch_valid_d = 1'b0;
                        busy_d        = 1'b1;
                        state_d       = ST_COND;
`ifdef BRANCH_LINK_EN
                        link_pend_d   = br_link;
                        lr_pend_d     = lr_now;
`endif
                    end
                end else if (!stall) begin
                    fetch_addr_d = fetch_addr_q + HALFWORD;
                end
            end
            ST_COND: begin
                if (cond_ok) begin
                    redir = 1'b1;
                end else begin
                    fetch_addr_d  = fetch_addr_q + HALFWORD;
                    fetch_valid_d = 1'b1;
                    state_d       = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (cnt_q != 4'd0) begin
                    cnt_d   = cnt_q - 4'd1;
                    flush_d = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    fetch_valid_d = 1'b1;
                    state_d       = ST_RUN;
                end
            end
            default: state_d = ST_INIT;
        endcase

        // Shared by unconditional branches and taken conditional branches.
        if (redir) begin
            fetch_addr_d  = redir_tgt;
            fetch_valid_d = 1'b0;
            taken_d       = 1'b1;
            flush_d       = 1'b1;
            busy_d        = 1'b1;
            cnt_d         = FLUSH_INIT;
            state_d       = ST_FLUSH;
`ifdef BRANCH_LINK_EN
            if (redir_link) begin
                lr_d    = redir_lr;
                lr_we_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_INIT;
            fetch_addr_q  <= RESET_PC;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            taken_q       <= 1'b0;
            busy_q        <= 1'b0;
            cnt_q         <= 4'd0;
            tgt_q         <= '0;
`ifdef BRANCH_LINK_EN
            link_pend_q   <= 1'b0;
            lr_pend_q     <= '0;
            lr_q          <= '0;
            lr_we_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            fetch_addr_q  <= fetch_addr_d;
            fetch_valid_q <= fetch_valid_d;
            flush_q       <= flush_d;
            taken_q       <= taken_d;
            busy_q        <= busy_d;
            cnt_q         <= cnt_d;
            tgt_q         <= tgt_d;
`ifdef BRANCH_LINK_EN
            link_pend_q   <= link_pend_d;
            lr_pend_q     <= lr_pend_d;
            lr_q          <= lr_d;
            lr_we_q       <= lr_we_d;
`endif
        end
    end

    assign fetch_addr  = fetch_addr_q;
    assign fetch_valid = fetch_valid_q;
    assign flush       = flush_q;
    assign taken       = taken_q;
    assign busy        = busy_q;
`ifdef BRANCH_LINK_EN
    assign lr          = lr_q;
    assign lr_we       = lr_we_q;
`endif

endmodule

`default_nettype wire
